// File: rtl/cfg_dma_pkg.sv
// rtl/cfg_dma_pkg.sv - register offsets, FSM state type and bit indices for cfg_dma_regs
package cfg_dma_pkg;

  // Word offsets (byte address bits [7:2]) of the register map
  localparam logic [5:0] OFF_ID     = 6'h00;  // 0x00
  localparam logic [5:0] OFF_SRC_LO = 6'h04;  // 0x10
  localparam logic [5:0] OFF_SRC_HI = 6'h05;  // 0x14
  localparam logic [5:0] OFF_DST_LO = 6'h06;  // 0x18
  localparam logic [5:0] OFF_DST_HI = 6'h07;  // 0x1C
  localparam logic [5:0] OFF_LEN    = 6'h08;  // 0x20
  localparam logic [5:0] OFF_CTRL   = 6'h09;  // 0x24
  localparam logic [5:0] OFF_STATUS = 6'h0A;  // 0x28
  localparam logic [5:0] OFF_DONE   = 6'h0B;  // 0x2C

  // CTRL / STATUS / DONE bit positions
  localparam int CTRL_START_BIT  = 0;
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_ERR_BIT  = 1;
  localparam int STATUS_WDOG_BIT = 2;
  localparam int DONE_BIT        = 0;

  // Transfer sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2
  } dma_state_e;

endpackage

// File: rtl/cfg_dma_regs.sv
// rtl/cfg_dma_regs.sv - register block that programs and launches a single DMA transfer
module cfg_dma_regs
  import cfg_dma_pkg::*;
#(
  parameter logic [31:0] ID_VALUE    = 32'h0001_0000,
  parameter int unsigned WDOG_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_req_valid,
  input  logic        cfg_req_we,
  input  logic [31:0] cfg_req_addr,
  input  logic [31:0] cfg_req_wdata,
  output logic        cfg_resp_valid,
  output logic [31:0] cfg_resp_rdata,
  output logic        dma_cmd_valid,
  input  logic        dma_cmd_ready,
  output logic [63:0] dma_cmd_src,
  output logic [63:0] dma_cmd_dst,
  output logic [31:0] dma_cmd_len,
  input  logic        dma_done,
  input  logic        dma_err
);

  // Counter only has to reach WDOG_CYCLES-1; the timeout fires on the edge after that value
  localparam int CNT_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_CYCLES - 1);

  dma_state_e state;

  logic [31:0] src_lo, src_hi, dst_lo, dst_hi, len_reg;
  logic        done_flag, err_flag, wdog_flag;
  logic [CNT_W-1:0] wdog_cnt;

  logic        in_map;
  logic [5:0]  word;
  logic        wr_en, rd_en, is_idle;
  logic        start_req, done_clr;
  logic [31:0] rdata;
  logic        unused_addr_bits;

  // Byte lanes within a word are not decoded
  assign unused_addr_bits = ^cfg_req_addr[1:0];

  assign in_map    = (cfg_req_addr[31:8] == 24'd0);
  assign word      = cfg_req_addr[7:2];
  assign wr_en     = cfg_req_valid & cfg_req_we & in_map;
  assign rd_en     = cfg_req_valid & ~cfg_req_we & in_map;
  assign is_idle   = (state == ST_IDLE);
  assign start_req = wr_en && (word == OFF_CTRL) && cfg_req_wdata[CTRL_START_BIT];
  assign done_clr  = wr_en && (word == OFF_DONE) && cfg_req_wdata[DONE_BIT];

  // Command fields come straight from the registers, which are frozen outside IDLE
  assign dma_cmd_valid = (state == ST_ISSUE);
  assign dma_cmd_src   = {src_hi, src_lo};
  assign dma_cmd_dst   = {dst_hi, dst_lo};
  assign dma_cmd_len   = len_reg;

  assign cfg_resp_valid = cfg_req_valid;
  assign cfg_resp_rdata = rdata;

  // Programmable transfer registers; only writable while no transfer is in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      src_lo  <= 32'd0;
      src_hi  <= 32'd0;
      dst_lo  <= 32'd0;
      dst_hi  <= 32'd0;
      len_reg <= 32'd0;
    end else if (wr_en && is_idle) begin
      case (word)
        OFF_SRC_LO: src_lo  <= cfg_req_wdata;
        OFF_SRC_HI: src_hi  <= cfg_req_wdata;
        OFF_DST_LO: dst_lo  <= cfg_req_wdata;
        OFF_DST_HI: dst_hi  <= cfg_req_wdata;
        OFF_LEN:    len_reg <= cfg_req_wdata;
        default:    ;
      endcase
    end
  end

  // Transfer sequencer with watchdog and sticky DONE/error/watchdog flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      done_flag <= 1'b0;
      err_flag  <= 1'b0;
      wdog_flag <= 1'b0;
      wdog_cnt  <= '0;
    end else begin
      // Clear first so that a completion in the same cycle wins
      if (done_clr) begin
        done_flag <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (start_req) begin
            if (len_reg != 32'd0) begin
              state     <= ST_ISSUE;
              done_flag <= 1'b0;
              err_flag  <= 1'b0;
              wdog_flag <= 1'b0;
            end else begin
              done_flag <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (dma_cmd_ready) begin
            state    <= ST_BUSY;
            wdog_cnt <= '0;
          end
          if (start_req) begin
            err_flag <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (dma_done) begin
            state     <= ST_IDLE;
            done_flag <= 1'b1;
            err_flag  <= dma_err;
          end else if (wdog_cnt == WDOG_LAST) begin
            state     <= ST_IDLE;
            done_flag <= 1'b1;
            err_flag  <= 1'b1;
            wdog_flag <= 1'b1;
          end else begin
            wdog_cnt <= wdog_cnt + 1'b1;
          end
          // A rejected START must stay visible even if the engine reports success
          if (start_req) begin
            err_flag <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Zero-latency read mux; writes and idle cycles return zero
  always_comb begin
    rdata = 32'd0;
    if (rd_en) begin
      case (word)
        OFF_ID:     rdata = ID_VALUE;
        OFF_SRC_LO: rdata = src_lo;
        OFF_SRC_HI: rdata = src_hi;
        OFF_DST_LO: rdata = dst_lo;
        OFF_DST_HI: rdata = dst_hi;
        OFF_LEN:    rdata = len_reg;
        OFF_STATUS: begin
          rdata[STATUS_BUSY_BIT] = ~is_idle;
          rdata[STATUS_ERR_BIT]  = err_flag;
          rdata[STATUS_WDOG_BIT] = wdog_flag;
        end
        OFF_DONE:   rdata[DONE_BIT] = done_flag;
        default:    rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_dma_regs.sv
// tb/tb_cfg_dma_regs.sv - self-checking bench for cfg_dma_regs
module tb_cfg_dma_regs;

  localparam logic [31:0] ID_EXP = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_req_valid, cfg_req_we;
  logic [31:0] cfg_req_addr, cfg_req_wdata;
  logic        cfg_resp_valid;
  logic [31:0] cfg_resp_rdata;
  logic        dma_cmd_valid, dma_cmd_ready;
  logic [63:0] dma_cmd_src, dma_cmd_dst;
  logic [31:0] dma_cmd_len;
  logic        dma_done, dma_err;

  int errors = 0;
  int checks = 0;
  int cmd_count = 0;

  always #5 clk = ~clk;

  cfg_dma_regs #(.ID_VALUE(32'h0001_0000), .WDOG_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .cfg_req_valid(cfg_req_valid), .cfg_req_we(cfg_req_we),
    .cfg_req_addr(cfg_req_addr), .cfg_req_wdata(cfg_req_wdata),
    .cfg_resp_valid(cfg_resp_valid), .cfg_resp_rdata(cfg_resp_rdata),
    .dma_cmd_valid(dma_cmd_valid), .dma_cmd_ready(dma_cmd_ready),
    .dma_cmd_src(dma_cmd_src), .dma_cmd_dst(dma_cmd_dst), .dma_cmd_len(dma_cmd_len),
    .dma_done(dma_done), .dma_err(dma_err)
  );

  // Count accepted commands independently of the register view
  always @(posedge clk) begin
    if (dma_cmd_valid && dma_cmd_ready) cmd_count++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got time %0t expected < 500000", $time);
    $fatal(1);
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    cfg_req_valid = 1'b1; cfg_req_we = 1'b1; cfg_req_addr = a; cfg_req_wdata = d;
    @(posedge clk); #1;
    cfg_req_valid = 1'b0; cfg_req_we = 1'b0; cfg_req_addr = 32'd0; cfg_req_wdata = 32'd0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    cfg_req_valid = 1'b1; cfg_req_we = 1'b0; cfg_req_addr = a;
    #1 d = cfg_resp_rdata;
    @(posedge clk); #1;
    cfg_req_valid = 1'b0; cfg_req_addr = 32'd0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [31:0] offs [8] = '{32'h10, 32'h14, 32'h18, 32'h1C, 32'h20, 32'h24, 32'h28, 32'h2C};
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    bus_read(32'h00, d);
    checks++; if (d !== ID_EXP) begin errors++; $display("FAIL reset_id: got %h expected %h", d, ID_EXP); end
    foreach (offs[i]) begin
      bus_read(offs[i], d);
      checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_reg_%h: got %h expected 0", offs[i], d); end
    end
    checks++;
    if ({dma_cmd_valid, dma_cmd_src, dma_cmd_dst, dma_cmd_len} !== 161'd0) begin
      errors++; $display("FAIL reset_cmd: got valid=%b src=%h dst=%h len=%h expected all 0",
                        dma_cmd_valid, dma_cmd_src, dma_cmd_dst, dma_cmd_len);
    end
  endtask

  // One full programmed transfer; expectations come from the programmed values and the engine's answer
  task automatic run_transfer(input string name, input logic [63:0] src, input logic [63:0] dst,
                              input logic [31:0] len, input int rdy_dly, input int done_dly,
                              input logic err);
    logic [31:0] d;
    int base;
    bus_write(32'h10, src[31:0]);  bus_write(32'h14, src[63:32]);
    bus_write(32'h18, dst[31:0]);  bus_write(32'h1C, dst[63:32]);
    bus_write(32'h20, len);
    base = cmd_count;
    bus_write(32'h24, 32'h1);
    for (int k = 0; k <= rdy_dly; k++) begin
      dma_cmd_ready = (k == rdy_dly);
      checks++;
      if ({dma_cmd_valid, dma_cmd_src, dma_cmd_dst, dma_cmd_len} !== {1'b1, src, dst, len}) begin
        errors++; $display("FAIL %s_cmd: got valid=%b src=%h dst=%h len=%h expected 1 %h %h %h",
                          name, dma_cmd_valid, dma_cmd_src, dma_cmd_dst, dma_cmd_len, src, dst, len);
      end
      bus_read(32'h28, d);
      checks++; if (d[0] !== 1'b1) begin errors++; $display("FAIL %s_busy_issue: got %b expected 1", name, d[0]); end
    end
    dma_cmd_ready = 1'b0;
    for (int j = 1; j <= done_dly; j++) begin
      if (j == done_dly) begin dma_done = 1'b1; dma_err = err; end
      checks++; if (dma_cmd_valid !== 1'b0) begin errors++; $display("FAIL %s_valid_busy: got %b expected 0", name, dma_cmd_valid); end
      bus_read(32'h28, d);
      checks++; if (d[0] !== 1'b1) begin errors++; $display("FAIL %s_busy_wait: got %b expected 1", name, d[0]); end
      dma_done = 1'b0; dma_err = 1'b0;
    end
    bus_read(32'h28, d);
    checks++; if (d !== (err ? 32'h2 : 32'h0)) begin errors++; $display("FAIL %s_status: got %h expected %h", name, d, err ? 32'h2 : 32'h0); end
    bus_read(32'h2C, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL %s_done: got %h expected 1", name, d); end
    checks++; if (cmd_count !== base + 1) begin errors++; $display("FAIL %s_cmd_count: got %0d expected %0d", name, cmd_count - base, 1); end
  endtask

  task automatic test_basic();
    run_transfer("basic", 64'h1000, 64'h2000, 32'd16, 2, 5, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      run_transfer("random", {$urandom, $urandom}, {$urandom, $urandom}, $urandom | 32'h1,
                   $urandom_range(0, 3), $urandom_range(1, 7), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_len_zero();
    logic [31:0] d;
    int base;
    bus_write(32'h2C, 32'h1);
    bus_read(32'h2C, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL lenzero_pre_done: got %h expected 0", d); end
    bus_write(32'h20, 32'h0);
    base = cmd_count;
    bus_write(32'h24, 32'h1);
    checks++; if (dma_cmd_valid !== 1'b0) begin errors++; $display("FAIL lenzero_valid: got %b expected 0", dma_cmd_valid); end
    bus_read(32'h2C, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL lenzero_done: got %h expected 1", d); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (dma_cmd_valid !== 1'b0) begin errors++; $display("FAIL lenzero_idle_valid: got %b expected 0", dma_cmd_valid); end
      @(posedge clk); #1;
    end
    checks++; if (cmd_count !== base) begin errors++; $display("FAIL lenzero_cmds: got %0d expected 0", cmd_count - base); end
  endtask

  task automatic test_watchdog();
    logic [31:0] d;
    bus_write(32'h20, 32'd4);
    bus_write(32'h24, 32'h1);
    dma_cmd_ready = 1'b1; @(posedge clk); #1; dma_cmd_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      bus_read(32'h28, d);
      checks++; if (d[0] !== 1'b1) begin errors++; $display("FAIL wdog_busy_cycle%0d: got %b expected 1", i, d[0]); end
    end
    bus_read(32'h28, d);
    checks++; if (d !== 32'h6) begin errors++; $display("FAIL wdog_status: got %h expected 6", d); end
    bus_read(32'h2C, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL wdog_done: got %h expected 1", d); end
  endtask

  task automatic test_busy_writes();
    logic [31:0] d;
    int base;
    bus_write(32'h20, 32'd32);
    base = cmd_count;
    bus_write(32'h24, 32'h1);
    dma_cmd_ready = 1'b1; @(posedge clk); #1; dma_cmd_ready = 1'b0;
    bus_write(32'h20, 32'h55);
    bus_write(32'h24, 32'h1);
    bus_read(32'h28, d);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL busywr_status: got %h expected 3", d); end
    bus_read(32'h20, d);
    checks++; if (d !== 32'd32) begin errors++; $display("FAIL busywr_len: got %h expected %h", d, 32'd32); end
    dma_done = 1'b1; @(posedge clk); #1; dma_done = 1'b0;
    repeat (3) @(posedge clk); #1;
    checks++; if (cmd_count !== base + 1) begin errors++; $display("FAIL busywr_cmds: got %0d expected 1", cmd_count - base); end
    bus_read(32'h28, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL busywr_status_after: got %h expected 0", d); end
  endtask

  task automatic test_done_race();
    logic [31:0] d;
    bus_write(32'h20, 32'd8);
    bus_write(32'h24, 32'h1);
    dma_cmd_ready = 1'b1; @(posedge clk); #1; dma_cmd_ready = 1'b0;
    dma_done = 1'b1;
    bus_write(32'h2C, 32'h1);
    dma_done = 1'b0;
    bus_read(32'h2C, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL race_done_set: got %h expected 1", d); end
    bus_write(32'h2C, 32'h1);
    bus_read(32'h2C, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL race_done_clr: got %h expected 0", d); end
  endtask

  task automatic test_rst_busy();
    logic [31:0] d;
    logic [31:0] offs [8] = '{32'h10, 32'h14, 32'h18, 32'h1C, 32'h20, 32'h24, 32'h28, 32'h2C};
    bus_write(32'h10, 32'hAAAA_0000); bus_write(32'h1C, 32'h0000_BBBB); bus_write(32'h20, 32'd64);
    bus_write(32'h24, 32'h1);
    dma_cmd_ready = 1'b1; @(posedge clk); #1; dma_cmd_ready = 1'b0;
    rst = 1'b1; @(posedge clk); #1;
    cfg_req_valid = 1'b1; cfg_req_we = 1'b0; cfg_req_addr = 32'h00;
    #1;
    checks++; if ({cfg_resp_valid, cfg_resp_rdata} !== {1'b1, ID_EXP}) begin
      errors++; $display("FAIL rst_read_id: got %b %h expected 1 %h", cfg_resp_valid, cfg_resp_rdata, ID_EXP); end
    cfg_req_addr = 32'h20; #1;
    checks++; if (cfg_resp_rdata !== 32'd0) begin errors++; $display("FAIL rst_read_len: got %h expected 0", cfg_resp_rdata); end
    @(posedge clk); #1;
    rst = 1'b0; cfg_req_valid = 1'b0; cfg_req_addr = 32'd0;
    dma_done = 1'b1; dma_err = 1'b1; @(posedge clk); #1; dma_done = 1'b0; dma_err = 1'b0;
    foreach (offs[i]) begin
      bus_read(offs[i], d);
      checks++; if (d !== 32'd0) begin errors++; $display("FAIL rst_busy_reg_%h: got %h expected 0", offs[i], d); end
    end
    checks++;
    if ({dma_cmd_valid, dma_cmd_src, dma_cmd_dst, dma_cmd_len} !== 161'd0) begin
      errors++; $display("FAIL rst_busy_cmd: got valid=%b src=%h dst=%h len=%h expected all 0",
                        dma_cmd_valid, dma_cmd_src, dma_cmd_dst, dma_cmd_len);
    end
    bus_read(32'h00, d);
    checks++; if (d !== ID_EXP) begin errors++; $display("FAIL rst_busy_id: got %h expected %h", d, ID_EXP); end
    bus_read(32'h104, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL unmapped_read: got %h expected 0", d); end
    // Byte-lane bits ignored; upper address bits make an access unmapped
    bus_write(32'h23, 32'h77);
    bus_write(32'h120, 32'h99);
    bus_read(32'h21, d);
    checks++; if (d !== 32'h77) begin errors++; $display("FAIL alias_len: got %h expected 77", d); end
    cfg_req_valid = 1'b1; cfg_req_we = 1'b1; cfg_req_addr = 32'h00; cfg_req_wdata = 32'hFFFF_FFFF; #1;
    checks++; if ({cfg_resp_valid, cfg_resp_rdata} !== {1'b1, 32'd0}) begin
      errors++; $display("FAIL write_rdata: got %b %h expected 1 0", cfg_resp_valid, cfg_resp_rdata); end
    cfg_req_valid = 1'b0; cfg_req_we = 1'b0; #1;
    checks++; if ({cfg_resp_valid, cfg_resp_rdata} !== 33'd0) begin
      errors++; $display("FAIL idle_resp: got %b %h expected 0 0", cfg_resp_valid, cfg_resp_rdata); end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    cfg_req_valid = 1'b0; cfg_req_we = 1'b0; cfg_req_addr = 32'd0; cfg_req_wdata = 32'd0;
    dma_cmd_ready = 1'b0; dma_done = 1'b0; dma_err = 1'b0;
    repeat (3) @(posedge clk); #1;
    test_reset();
    test_basic();
    test_len_zero();
    test_watchdog();
    test_busy_writes();
    test_done_race();
    test_random();
    test_rst_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cfg_dma_regs.md
CFG_DMA_REGS -- requirements
Module: cfg_dma_regs

Interface
REQ-001 SHALL have parameter ID_VALUE, default 32'h0001_0000, value returned by the ID register.
REQ-002 SHALL have parameter WDOG_CYCLES, default 1024, maximum BUSY cycles before the watchdog fires.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cfg_req_valid  input  1  request strobe, one cycle per access.
REQ-006 SHALL have port cfg_req_we  input  1  1 = write, 0 = read.
REQ-007 SHALL have port cfg_req_addr  input  32  byte address.
REQ-008 SHALL have port cfg_req_wdata  input  32  write data.
REQ-009 SHALL have port cfg_resp_valid  output  1  response strobe.
REQ-010 SHALL have port cfg_resp_rdata  output  32  read data.
REQ-011 SHALL have port dma_cmd_valid  output  1  command offer to the DMA engine.
REQ-012 SHALL have port dma_cmd_ready  input  1  engine accepts the command.
REQ-013 SHALL have ports dma_cmd_src / dma_cmd_dst  output  64 each  byte addresses; dma_cmd_len  output  32  byte count.
REQ-014 SHALL have ports dma_done  input  1  completion pulse; dma_err  input  1  error qualifier, valid with dma_done.

Function
REQ-015 Register map SHALL be: 0x00 ID (RO); 0x10/0x14 SRC lo/hi; 0x18/0x1C DST lo/hi; 0x20 LEN (RW); 0x24 CTRL (bit0 START, write-1 pulse, reads 0); 0x28 STATUS (RO: bit0 busy, bit1 error, bit2 watchdog); 0x2C DONE (bit0 sticky; write 1 clears).
REQ-016 Decode SHALL use addr[7:2]; addr[1:0] ignored; any nonzero addr[31:8] or unlisted offset is unmapped: reads 0, writes ignored.
REQ-017 cfg_resp_valid SHALL equal cfg_req_valid combinationally; read data SHALL be combinational in the same cycle (zero latency); write data SHALL be captured at the clock edge ending the request cycle.
REQ-018 cfg_resp_rdata SHALL be 0 when cfg_req_valid=0 or cfg_req_we=1.
REQ-019 The FSM SHALL have states IDLE, ISSUE, BUSY.
REQ-020 IDLE + START write with LEN!=0 -> ISSUE; DONE and error/watchdog bits cleared on that edge.
REQ-021 IDLE + START with LEN==0 -> remain IDLE, DONE=1 next cycle, no command issued.
REQ-022 ISSUE: dma_cmd_valid=1 with src/dst/len stable from registers; on valid&&ready -> BUSY.
REQ-023 BUSY: on dma_done -> IDLE, DONE=1, error=dma_err.
REQ-024 Watchdog counter SHALL clear on BUSY entry and increment each BUSY cycle; on reaching WDOG_CYCLES without dma_done -> IDLE, DONE=1, error=1, watchdog=1.
REQ-025 START while not IDLE SHALL be ignored and SHALL set error=1.
REQ-026 Writes to SRC/DST/LEN while not IDLE SHALL be ignored.
REQ-027 STATUS.busy SHALL be 1 in ISSUE or BUSY.
REQ-028 dma_done outside BUSY SHALL be ignored.
REQ-029 A same-cycle DONE write-1-clear and DONE set SHALL resolve to set.
REQ-030 dma_cmd_valid SHALL never deassert in ISSUE before ready.

Reset
REQ-031 rst SHALL force IDLE, all RW registers 0, DONE/error/watchdog 0, watchdog counter 0, dma_cmd_valid=0, dma_cmd_src/dst/len=0.
REQ-032 rst mid-ISSUE or mid-BUSY SHALL abandon the transfer; a later dma_done SHALL be ignored.
REQ-033 cfg_resp_valid/rdata SHALL follow REQ-017/018 during reset (read data shows reset values).

Structure
REQ-034 Package cfg_dma_pkg SHALL hold register offset localparams, the FSM state enum, and CTRL/STATUS bit indices.
REQ-035 No sub-module is required; the watchdog counter stays inline.

Verification
REQ-036 Program SRC=0x1000, DST=0x2000, LEN=16, START; ready 2 cycles later; dma_done 5 cycles after acceptance -> cmd fields exact, STATUS.busy=1 throughout, DONE reads 1, error=0.
REQ-037 LEN=0, START -> no dma_cmd_valid; DONE reads 1 the following cycle.
REQ-038 WDOG_CYCLES=8, no dma_done -> DONE=1 and STATUS=0b110 after exactly 8 BUSY cycles.
REQ-039 START and LEN write during BUSY -> STATUS.error=1, LEN readback unchanged, single command only.
REQ-040 Write 1 to DONE in the same cycle as dma_done -> DONE remains 1; next clear -> 0.
REQ-041 Assert rst in BUSY, then pulse dma_done -> all registers 0, DONE=0, state IDLE; ID reads 0x0001_0000; unmapped 0x104 reads 0.
